// File: rtl/regfile_scoreboard_if.sv
// Bus interface for regfile_scoreboard: write port, allocate port, two read
// ports with their busy flags, and the aggregate busy indication.
// master = decode/execute side driving the file, slave = the register file.
interface regfile_scoreboard_if #(
    parameter int WIDTH = 64,
    parameter int SEL_W = 5
);
    logic             write;
    logic [SEL_W-1:0] sel_w;
    logic [WIDTH-1:0] data_in;
    logic [SEL_W-1:0] sel_r1;
    logic [SEL_W-1:0] sel_r2;
    logic [WIDTH-1:0] data_out1;
    logic [WIDTH-1:0] data_out2;
    logic             alloc;
    logic [SEL_W-1:0] sel_a;
    logic             busy1;
    logic             busy2;
    logic             any_busy;

    modport master (
        output write, sel_w, data_in, sel_r1, sel_r2, alloc, sel_a,
        input  data_out1, data_out2, busy1, busy2, any_busy
    );

    modport slave (
        input  write, sel_w, data_in, sel_r1, sel_r2, alloc, sel_a,
        output data_out1, data_out2, busy1, busy2, any_busy
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised register file with a per-register busy
// scoreboard. Two combinational read ports, one clocked write port and one
// clocked allocate port. ZERO_REG selects a hardwired-zero index (-1: none).
// Optional macro REGFILE_BYPASS_EN forwards the in-flight write data (and
// clears the reported busy flag) to a read port selecting the same register.
module regfile_scoreboard #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int SEL_W    = 5,
    parameter int ZERO_REG = 31
) (
    input logic                clk,
    input logic                rst,
    regfile_scoreboard_if.slave bus
);

    // An index is backed by storage only when in range and not the zero register.
    function automatic logic idx_ok(input logic [SEL_W-1:0] sel);
        return (int'(sel) < DEPTH) && (int'(sel) != ZERO_REG);
    endfunction

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;
    logic             wr_ok;
    logic             al_ok;
    logic [WIDTH-1:0] rd_data1;
    logic [WIDTH-1:0] rd_data2;
    logic             rd_busy1;
    logic             rd_busy2;

    assign wr_ok = bus.write && idx_ok(bus.sel_w);
    assign al_ok = bus.alloc && idx_ok(bus.sel_a);

    // Next scoreboard: a write retires its producer, an allocate issues a new one (allocate wins).
    always_comb begin
        busy_next = busy;
        if (wr_ok) begin
            busy_next[bus.sel_w] = 1'b0;
        end else begin
            busy_next = busy_next;
        end
        if (al_ok) begin
            busy_next[bus.sel_a] = 1'b1;
        end else begin
            busy_next = busy_next;
        end
    end

    // Data storage: asynchronous clear, otherwise accept a valid write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[bus.sel_w] <= bus.data_in;
        end
    end

    // Busy flags: asynchronous clear, otherwise load the computed scoreboard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Read port 1: stored value (or forwarded write data), zero for unbacked indices.
    always_comb begin
        rd_data1 = '0;
        rd_busy1 = 1'b0;
        if (rst) begin
            rd_data1 = '0;
            rd_busy1 = 1'b0;
        end else if (idx_ok(bus.sel_r1)) begin
            rd_data1 = regs[bus.sel_r1];
            rd_busy1 = busy[bus.sel_r1];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (bus.sel_w == bus.sel_r1)) begin
                rd_data1 = bus.data_in;
                rd_busy1 = al_ok && (bus.sel_a == bus.sel_w);
            end else begin
                rd_busy1 = rd_busy1;
            end
`endif
        end else begin
            rd_data1 = '0;
            rd_busy1 = 1'b0;
        end
    end

    // Read port 2: same rules as port 1 on sel_r2.
    always_comb begin
        rd_data2 = '0;
        rd_busy2 = 1'b0;
        if (rst) begin
            rd_data2 = '0;
            rd_busy2 = 1'b0;
        end else if (idx_ok(bus.sel_r2)) begin
            rd_data2 = regs[bus.sel_r2];
            rd_busy2 = busy[bus.sel_r2];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (bus.sel_w == bus.sel_r2)) begin
                rd_data2 = bus.data_in;
                rd_busy2 = al_ok && (bus.sel_a == bus.sel_w);
            end else begin
                rd_busy2 = rd_busy2;
            end
`endif
        end else begin
            rd_data2 = '0;
            rd_busy2 = 1'b0;
        end
    end

    assign bus.data_out1 = rd_data1;
    assign bus.data_out2 = rd_data2;
    assign bus.busy1     = rd_busy1;
    assign bus.busy2     = rd_busy2;
    assign bus.any_busy  = (!rst) && (|busy);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: two instances (ZERO_REG=31 and ZERO_REG=-1)
// share one directed stimulus stream; an array-based model of the register
// file is checked on every falling edge, plus literal spot checks.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        t_write = 1'b0;
    logic [4:0]  t_sel_w = 5'd0;
    logic [63:0] t_data_in = 64'd0;
    logic [4:0]  t_sel_r1 = 5'd0;
    logic [4:0]  t_sel_r2 = 5'd0;
    logic        t_alloc = 1'b0;
    logic [4:0]  t_sel_a = 5'd0;

    int checks = 0;
    int errors = 0;

    logic [63:0] mem_m  [2][32];
    logic [31:0] busy_m [2];

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.WIDTH(64), .SEL_W(5)) bus0 ();
    regfile_scoreboard_if #(.WIDTH(64), .SEL_W(5)) bus1 ();

    assign bus0.write = t_write;   assign bus1.write = t_write;
    assign bus0.sel_w = t_sel_w;   assign bus1.sel_w = t_sel_w;
    assign bus0.data_in = t_data_in; assign bus1.data_in = t_data_in;
    assign bus0.sel_r1 = t_sel_r1; assign bus1.sel_r1 = t_sel_r1;
    assign bus0.sel_r2 = t_sel_r2; assign bus1.sel_r2 = t_sel_r2;
    assign bus0.alloc = t_alloc;   assign bus1.alloc = t_alloc;
    assign bus0.sel_a = t_sel_a;   assign bus1.sel_a = t_sel_a;

    regfile_scoreboard #(.WIDTH(64), .DEPTH(32), .SEL_W(5), .ZERO_REG(31)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave));
    regfile_scoreboard #(.WIDTH(64), .DEPTH(32), .SEL_W(5), .ZERO_REG(-1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave));

    function automatic bit backed(input int inst, input logic [4:0] sel);
        int zr;
        zr = (inst == 0) ? 31 : -1;
        return int'(sel) != zr;
    endfunction

    function automatic logic [63:0] exp_data(input int inst, input logic [4:0] sel);
        if (rst || !backed(inst, sel)) return 64'd0;
`ifdef REGFILE_BYPASS_EN
        if (t_write && t_sel_w == sel) return t_data_in;
`endif
        return mem_m[inst][sel];
    endfunction

    function automatic logic exp_busy(input int inst, input logic [4:0] sel);
        if (rst || !backed(inst, sel)) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (t_write && t_sel_w == sel) return t_alloc && (t_sel_a == sel);
`endif
        return busy_m[inst][sel];
    endfunction

    // Reference model: reset wipes everything; a write stores data and retires
    // the producer, an allocate marks busy afterwards so it wins on a tie.
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                for (int r = 0; r < 32; r++) mem_m[i][r] <= 64'd0;
                busy_m[i] <= 32'd0;
            end else begin
                logic [31:0] nb;
                nb = busy_m[i];
                if (t_write && backed(i, t_sel_w)) begin
                    mem_m[i][t_sel_w] <= t_data_in;
                    nb[t_sel_w] = 1'b0;
                end
                if (t_alloc && backed(i, t_sel_a)) nb[t_sel_a] = 1'b1;
                busy_m[i] <= nb;
            end
        end
    end

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        cmp("m0.data_out1", bus0.data_out1, exp_data(0, t_sel_r1));
        cmp("m0.data_out2", bus0.data_out2, exp_data(0, t_sel_r2));
        cmp("m0.busy1", {63'd0, bus0.busy1}, {63'd0, exp_busy(0, t_sel_r1)});
        cmp("m0.busy2", {63'd0, bus0.busy2}, {63'd0, exp_busy(0, t_sel_r2)});
        cmp("m0.any_busy", {63'd0, bus0.any_busy}, {63'd0, (!rst) && (|busy_m[0])});
        cmp("m1.data_out1", bus1.data_out1, exp_data(1, t_sel_r1));
        cmp("m1.data_out2", bus1.data_out2, exp_data(1, t_sel_r2));
        cmp("m1.busy1", {63'd0, bus1.busy1}, {63'd0, exp_busy(1, t_sel_r1)});
        cmp("m1.busy2", {63'd0, bus1.busy2}, {63'd0, exp_busy(1, t_sel_r2)});
        cmp("m1.any_busy", {63'd0, bus1.any_busy}, {63'd0, (!rst) && (|busy_m[1])});
    endtask

    // Compare process: outputs against the model on every falling edge.
    always @(negedge clk) check_model();

    task automatic drive(input logic w, input logic [4:0] sw, input logic [63:0] din,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic a, input logic [4:0] sa);
        @(posedge clk);
        #1;
        t_write = w; t_sel_w = sw; t_data_in = din;
        t_sel_r1 = r1; t_sel_r2 = r2; t_alloc = a; t_sel_a = sa;
        @(negedge clk);
        #1;
    endtask

    initial begin
        t_sel_r1 = 5'd0;
        t_sel_r2 = 5'd30;
        #2;
        cmp("rst.data_out1", bus0.data_out1, 64'd0);
        cmp("rst.data_out2", bus0.data_out2, 64'd0);
        cmp("rst.busy1", {63'd0, bus0.busy1}, 64'd0);
        cmp("rst.any_busy", {63'd0, bus0.any_busy}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        drive(1'b1, 5'd0,  64'h1234567812345678, 5'd0, 5'd30, 1'b0, 5'd0);
        drive(1'b1, 5'd30, 64'h00000000ffffffff, 5'd0, 5'd30, 1'b0, 5'd0);
        drive(1'b0, 5'd5,  64'h534642,           5'd0, 5'd30, 1'b0, 5'd0);
        cmp("r0.read", bus0.data_out1, 64'h1234567812345678);
        cmp("r30.read", bus0.data_out2, 64'h00000000ffffffff);
        drive(1'b0, 5'd5,  64'h534642,           5'd5, 5'd30, 1'b0, 5'd0);
        cmp("r5.nowrite", bus0.data_out1, 64'd0);

        drive(1'b1, 5'd31, 64'hDEADBEEF, 5'd0, 5'd0, 1'b0, 5'd0);
        drive(1'b0, 5'd0,  64'd0,        5'd31, 5'd31, 1'b0, 5'd0);
        cmp("zr31.read", bus0.data_out1, 64'd0);
        cmp("nozr.read", bus1.data_out1, 64'hDEADBEEF);

        drive(1'b0, 5'd0, 64'd0, 5'd7, 5'd0, 1'b1, 5'd7);
        cmp("alloc.pre_busy1", {63'd0, bus0.busy1}, 64'd0);
        drive(1'b0, 5'd0, 64'd0, 5'd7, 5'd0, 1'b0, 5'd0);
        cmp("alloc.busy1", {63'd0, bus0.busy1}, 64'd1);
        cmp("alloc.any_busy", {63'd0, bus0.any_busy}, 64'd1);
        drive(1'b1, 5'd7, 64'h42, 5'd7, 5'd0, 1'b0, 5'd0);
        drive(1'b0, 5'd0, 64'd0,  5'd7, 5'd0, 1'b0, 5'd0);
        cmp("wr7.busy1", {63'd0, bus0.busy1}, 64'd0);
        cmp("wr7.data", bus0.data_out1, 64'h42);
        cmp("wr7.any_busy", {63'd0, bus0.any_busy}, 64'd0);
        drive(1'b1, 5'd7, 64'h99, 5'd7, 5'd0, 1'b1, 5'd7);
        drive(1'b0, 5'd0, 64'd0,  5'd7, 5'd0, 1'b0, 5'd0);
        cmp("wralloc.busy1", {63'd0, bus0.busy1}, 64'd1);
        cmp("wralloc.data", bus0.data_out1, 64'h99);

        drive(1'b1, 5'd9, 64'hA5A5, 5'd0, 5'd9, 1'b0, 5'd0);
`ifdef REGFILE_BYPASS_EN
        cmp("byp.pre_edge", bus0.data_out2, 64'hA5A5);
`else
        cmp("byp.pre_edge", bus0.data_out2, 64'd0);
`endif
        drive(1'b0, 5'd0, 64'd0, 5'd0, 5'd9, 1'b0, 5'd0);
        cmp("byp.post_edge", bus0.data_out2, 64'hA5A5);

        drive(1'b1, 5'd10, 64'h5, 5'd10, 5'd11, 1'b1, 5'd11);
        drive(1'b1, 5'd3,  64'h77, 5'd10, 5'd11, 1'b0, 5'd0);
        cmp("diff.data10", bus0.data_out1, 64'h5);
        cmp("diff.busy11", {63'd0, bus0.busy2}, 64'd1);

        drive(1'b0, 5'd0, 64'd0, 5'd3, 5'd11, 1'b0, 5'd0);
        cmp("r3.before_rst", bus0.data_out1, 64'h77);
        @(posedge clk);
        #1;
        t_write = 1'b1; t_sel_w = 5'd3; t_data_in = 64'h55;
        #1 rst = 1'b1;
        #1;
        check_model();
        cmp("midrst.data", bus0.data_out1, 64'd0);
        cmp("midrst.any_busy", {63'd0, bus0.any_busy}, 64'd0);
        #1 rst = 1'b0;
        t_write = 1'b0;
        drive(1'b0, 5'd0, 64'd0, 5'd3, 5'd11, 1'b0, 5'd0);
        cmp("postrst.r3", bus0.data_out1, 64'd0);
        cmp("postrst.busy11", {63'd0, bus0.busy2}, 64'd0);
        cmp("postrst.any_busy", {63'd0, bus1.any_busy}, 64'd0);

        drive(1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b0, 5'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
